// File: rtl/mult32_sequencer_pkg.sv
// mult_pkg: shared state encoding and operand width for the sequential multiplier.
package mult_pkg;
    localparam int MULT_WIDTH = 32;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;
endpackage

// File: rtl/mult32_sequencer_if.sv
// mult32_sequencer_if: start/busy/done handshake plus operands and HI/LO product.
interface mult32_sequencer_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, multiplicand, multiplier, input busy, done, hi, lo);
    modport slave (input start, multiplicand, multiplier, output busy, done, hi, lo);
endinterface

// File: rtl/mult32_sequencer_adder.sv
// adder32_cout: ripple-carry adder (cin=0) built from full-adder cells, exposing carry-out.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder32_cout #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .sum(sum[i]), .cout(c[i+1]));
    end
    assign cout = c[WIDTH];
endmodule

// File: rtl/mult32_sequencer.sv
// mult32_sequencer: unsigned WIDTHxWIDTH shift-add multiplier, one adder step per clock,
// product held in hi/lo until the next accepted start.
module mult32_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 6
) (
    input logic                clk,
    input logic                reset,
    mult32_sequencer_if.slave  bus
);
    state_t           state, next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mcand, hi, lo, sum;
    logic             cout;

    adder32_cout #(.WIDTH(WIDTH)) u_add (
        .a(hi),
        .b(lo[0] ? mcand : '0),
        .sum(sum),
        .cout(cout)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= ST_IDLE;
        else state <= next;

    // Encoding 2'b11 is unreachable but falls back to IDLE.
    always_comb begin
        next = ST_IDLE;
        case (state)
            ST_IDLE: next = bus.start ? ST_RUN : ST_IDLE;
            ST_RUN:  next = (count == CNT_W'(WIDTH - 1)) ? ST_DONE : ST_RUN;
            default: next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = state != ST_IDLE;
        bus.done = state == ST_DONE;
        bus.hi   = hi;
        bus.lo   = lo;
    end

    // Carry-out lands in hi's MSB so the full double-width product is kept.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            count <= '0;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (state == ST_IDLE && bus.start) begin
            count <= '0;
            mcand <= bus.multiplicand;
            hi    <= '0;
            lo    <= bus.multiplier;
        end else if (state == ST_RUN) begin
            count     <= count + 1'b1;
            {hi, lo}  <= {cout, sum, lo[WIDTH-1:1]};
        end
endmodule

// File: tb/tb_mult32_sequencer.sv
// tb_mult32_sequencer: scoreboarded random/directed test of the sequential multiplier.
module tb_mult32_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [63:0] sb[$];

    mult32_sequencer_if bus ();
    mult32_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, {62'(bus.hi) ^ 62'(bus.lo << 30), bus.busy, bus.done} | {bus.hi, bus.lo}, 64'h0);
    endtask

    // Assumes caller is at a negedge with the DUT idle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit glitch, input int rst_at);
        int k;
        bus.start = 1'b1;
        bus.multiplicand = a;
        bus.multiplier = b;
        sb.push_back({32'h0, a} * {32'h0, b});
        @(negedge clk);
        bus.start = 1'b0;
        k = 1;
        while (!bus.done && k <= 40) begin
            if (k == 5) check("busy_in_run", 64'(bus.busy), 64'h1);
            if (glitch && k == 5) begin
                bus.start = 1'b1;
                bus.multiplicand = $urandom;
                bus.multiplier = $urandom;
            end
            if (glitch && k == 6) bus.start = 1'b0;
            if (k == rst_at) begin
                #2 reset = 1'b1;
                #1 check_zero("async_reset");
                sb.delete();
                @(negedge clk);
                check_zero("reset_held");
                reset = 1'b0;
                return;
            end
            @(negedge clk);
            k++;
        end
        check("latency", 64'(k), 64'd33);
        if (glitch) begin
            bus.start = 1'b1;
            bus.multiplicand = $urandom;
            bus.multiplier = $urandom;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("idle_after_done", {62'h0, bus.busy, bus.done}, 64'h0);
    endtask

    always @(negedge clk)
        if (!reset && bus.done) begin
            if (sb.size() == 0) check("unexpected_done", 64'(bus.done), 64'h0);
            else check("product", {bus.hi, bus.lo}, sb.pop_front());
        end

    initial begin
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);
        do_op(32'd3, 32'd5, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(32'h1234_5678, 32'h0, 1'b0, 0);
        do_op(32'h8000_0000, 32'd2, 1'b0, 0);
        do_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 0);
        do_op(32'd11, 32'd13, 1'b0, 0);
        do_op(32'h0F0F_0F0F, 32'hAAAA_5555, 1'b0, 10);
        do_op(32'd7, 32'd6, 1'b0, 0);
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) a = 32'hFFFF_FFFF;
            if (i % 4 == 2) b = 32'h8000_0000 | b;
            do_op(a, b, i % 3 == 0, (i == 7) ? 3 : 0);
        end
        do_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0);
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
